// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a scan sequencer for row/digit strobing.
// Latency: one cycle from en/mode/w to f/idx/valid. No backpressure; the scan pauses while en=0.
module scan_decoder #(
    parameter int N          = 4,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [N-1:0]     w,
    input  logic [N-1:0]     last,
    output logic [2**N-1:0]  f,
    output logic [N-1:0]     idx,
    output logic             valid,
    output logic             wrap
);

    localparam int              M         = 2 ** N;
    localparam int              DW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DWELL_MAX = DW'(DWELL - 1);
    localparam logic [M-1:0]    F_OFF     = {M{ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DIRECT,
        ST_SCAN
    } state_t;

    state_t         state;
    logic [DW-1:0]  dwell;
    logic           rearm;
    logic [N-1:0]   idx_inc;
    logic           at_end;
    logic           past_last;

    assign idx_inc   = idx + 1'b1;
    assign at_end    = (dwell == DWELL_MAX);
    // idx above last only happens when last is lowered mid-scan; wrap at the next advance.
    assign past_last = (idx >= last);

    function automatic logic [M-1:0] decode(input logic [N-1:0] a);
        logic [M-1:0] oh;
        oh    = '0;
        oh[a] = 1'b1;
        return oh ^ F_OFF;
    endfunction

    // rearm remembers that mode was seen low since the last scan cycle, even while
    // disabled, so the next scan entry restarts at index 0 instead of resuming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
            f     <= F_OFF;
            idx   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            dwell <= '0;
            rearm <= 1'b1;
        end else if (!en) begin
            state <= ST_OFF;
            f     <= F_OFF;
            valid <= 1'b0;
            wrap  <= 1'b0;
            if (!mode) begin
                rearm <= 1'b1;
            end
        end else if (!mode) begin
            state <= ST_DIRECT;
            idx   <= w;
            f     <= decode(w);
            valid <= 1'b1;
            wrap  <= 1'b0;
            dwell <= '0;
            rearm <= 1'b1;
        end else begin
            state <= ST_SCAN;
            valid <= 1'b1;
            rearm <= 1'b0;
            if (rearm || state == ST_DIRECT) begin
                idx   <= '0;
                dwell <= '0;
                f     <= decode('0);
                wrap  <= 1'b0;
            end else if (at_end) begin
                dwell <= '0;
                if (past_last) begin
                    idx  <= '0;
                    f    <= decode('0);
                    wrap <= 1'b1;
                end else begin
                    idx  <= idx_inc;
                    f    <= decode(idx_inc);
                    wrap <= 1'b0;
                end
            end else begin
                dwell <= dwell + 1'b1;
                f     <= decode(idx);
                wrap  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: reset, direct decode, scan timing, pause/resume, edge parameters.
module tb_scan_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  = 1'b0;
    logic        en   = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  w    = '0;
    logic [3:0]  last = '0;
    logic [15:0] f;
    logic [3:0]  idx;
    logic        valid;
    logic        wrap;

    logic        en1 = 1'b0, mode1 = 1'b0;
    logic [3:0]  w1 = '0, last1 = '0;
    logic [15:0] f1;
    logic [3:0]  idx1;
    logic        valid1, wrap1;

    logic        en2 = 1'b0, mode2 = 1'b0;
    logic [3:0]  w2 = '0, last2 = '0;
    logic [15:0] f2;
    logic [3:0]  idx2;
    logic        valid2, wrap2;

    int n_tests = 0;
    int n_fail  = 0;

    scan_decoder #(.N(4), .DWELL(4), .ACTIVE_LOW(1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .w(w), .last(last),
        .f(f), .idx(idx), .valid(valid), .wrap(wrap)
    );

    scan_decoder #(.N(4), .DWELL(1), .ACTIVE_LOW(1)) u_d1 (
        .clk(clk), .rst(rst), .en(en1), .mode(mode1), .w(w1), .last(last1),
        .f(f1), .idx(idx1), .valid(valid1), .wrap(wrap1)
    );

    scan_decoder #(.N(4), .DWELL(4), .ACTIVE_LOW(0)) u_al0 (
        .clk(clk), .rst(rst), .en(en2), .mode(mode2), .w(w2), .last(last2),
        .f(f2), .idx(idx2), .valid(valid2), .wrap(wrap2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic [15:0] fe, input logic [3:0] ie,
                            input logic ve, input logic we);
        chk({tag, "_f"},     32'(f),     32'(fe));
        chk({tag, "_idx"},   32'(idx),   32'(ie));
        chk({tag, "_valid"}, 32'(valid), 32'(ve));
        chk({tag, "_wrap"},  32'(wrap),  32'(we));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_f(input int i);
        logic [15:0] one;
        one = 16'h0001;
        return ~(one << i);
    endfunction

    initial begin
        #2 rst = 1'b1;
        #1;
        chk_main("reset", 16'hFFFF, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        en1   = 1'b1; mode1 = 1'b1; last1 = 4'd0;
        en2   = 1'b1; mode2 = 1'b0; w2    = 4'd0;

        en = 1'b1; mode = 1'b0; w = 4'd5;
        step;
        chk_main("direct_w5", 16'hFFDF, 4'd5, 1'b1, 1'b0);
        chk("al0_f", 32'(f2), 32'h0001);
        chk("al0_valid", 32'(valid2), 32'd1);
        w = 4'd15;
        step;
        chk_main("direct_w15", 16'h7FFF, 4'd15, 1'b1, 1'b0);

        last = 4'd3; mode = 1'b1;
        for (int c = 0; c <= 25; c++) begin
            int ei;
            step;
            ei = (c / 4) % 4;
            chk_main($sformatf("scan_c%0d", c), exp_f(ei), 4'(ei), 1'b1, c == 16);
            if (c < 4) begin
                chk("d1_f", 32'(f1), 32'hFFFE);
                chk("d1_wrap", 32'(wrap1), 32'd1);
            end
        end

        en = 1'b0;
        for (int p = 0; p < 5; p++) begin
            step;
            chk_main($sformatf("pause%0d", p), 16'hFFFF, 4'd2, 1'b0, 1'b0);
        end
        en = 1'b1;
        step;
        chk_main("resume0", exp_f(2), 4'd2, 1'b1, 1'b0);
        step;
        chk_main("resume1", exp_f(2), 4'd2, 1'b1, 1'b0);
        step;
        chk_main("resume2", exp_f(3), 4'd3, 1'b1, 1'b0);

        mode = 1'b0;
        step;
        mode = 1'b1; last = 4'd15;
        for (int c = 0; c <= 24; c++) begin
            step;
            chk($sformatf("long_idx_c%0d", c), 32'(idx), 32'(c / 4));
        end
        last = 4'd2;
        for (int c = 25; c <= 29; c++) begin
            step;
            chk_main($sformatf("lower_c%0d", c), (c < 28) ? exp_f(6) : exp_f(0),
                     (c < 28) ? 4'd6 : 4'd0, 1'b1, c == 28);
        end
        step; step; step;
        chk("lower_next_idx", 32'(idx), 32'd1);

        en = 1'b0; mode = 1'b0;
        step;
        chk_main("off_modechg", 16'hFFFF, 4'd1, 1'b0, 1'b0);
        en = 1'b1; mode = 1'b1;
        step;
        chk_main("restart", exp_f(0), 4'd0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step;
        chk("restart_adv_idx", 32'(idx), 32'd1);

        rst = 1'b1;
        #1;
        chk_main("async_reset", 16'hFFFF, 4'd0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        step;
        chk_main("post_reset", exp_f(0), 4'd0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step;
        chk("post_reset_adv_idx", 32'(idx), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, registered N-to-2^N active-low decoder with a built-in scan sequencer. In direct mode it decodes an applied address. In scan mode it steps an internal index through outputs 0..Last, holding each for DWELL cycles, for row/digit strobing. It replaces hierarchical 2-to-4 decoder trees wherever a clocked, glitch-free one-hot select or an automatic scan is needed (display digit drive, keypad row strobe).

## Interface
Parameters:
- N, default 4: address width; output count is 2^N.
- DWELL, default 4: clock cycles each output stays selected in scan mode; legal range 1..65535.
- ACTIVE_LOW, default 1: 1 means the selected output is 0 and others are 1; 0 inverts all F bits.

Ports:
- Clock  in  1  single system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- En  in  1  enable; 0 forces all outputs inactive and pauses the scan.
- Mode  in  1  0 = direct decode of W; 1 = scan.
- W  in  N  direct-mode address.
- Last  in  N  highest index visited in scan mode.
- F  out  2^N  registered decoded outputs; bit i corresponds to index i.
- Idx  out  N  registered index currently driven on F.
- Valid  out  1  1 when exactly one F bit is active.
- Wrap  out  1  one-cycle pulse when the scan returns from Last to 0.

## Operation
- Reset values (immediate, asynchronous): F all inactive (all 1s when ACTIVE_LOW=1), Idx=0, Valid=0, Wrap=0, dwell counter=0, state OFF.
- States:
  - OFF: entered when En=0.
  - DIRECT: entered when En=1 and Mode=0.
  - SCAN: entered when En=1 and Mode=1.
  - The state is re-evaluated every cycle from the registered En and Mode values.
- OFF:
  - F inactive, Valid=0, Wrap=0.
  - Idx and the dwell counter hold their values (the scan pauses).
- DIRECT:
  - Each cycle: Idx<=W, F<=one-hot(W), Valid=1, Wrap=0.
  - The dwell counter is cleared.
- SCAN:
  - On entry from DIRECT, or on any Mode 0->1 change: Idx<=0, dwell<=0.
  - On entry from OFF with Mode unchanged: resume at the held Idx and dwell.
  - While in SCAN, dwell increments each cycle.
  - When dwell==DWELL-1: dwell<=0 and Idx advances.
    - If Idx>=Last: Idx<=0 and Wrap pulses for one cycle, aligned with the cycle F shows index 0.
    - Otherwise: Idx<=Idx+1.
  - Idx>Last can only arise when Last is lowered mid-scan. It is treated as Idx>=Last, so the scan wraps at the next advance.
  - Last=0: output 0 is held continuously and Wrap pulses every DWELL cycles.
  - DWELL=1: the index advances every cycle.
- F is always one-hot(Idx), or inactive, registered. There are no decode glitches on F.
- Arithmetic: the dwell counter is ceil(log2(DWELL)) bits wide (minimum 1). Idx is an N-bit register and never exceeds 2^N-1.

## Timing
- Latency: W, En and Mode sampled at edge k are reflected on F, Idx and Valid after edge k. This is one cycle.
- Scan period is (Last+1)*DWELL cycles. Wrap is high for exactly 1 cycle per period.
- Simultaneous En 1->0 and a scan advance: En wins. The advance does not occur and Idx/dwell hold.
- Mode change and En=0 in the same cycle: the state goes to OFF, but the Mode change is recorded. On re-enable the scan restarts at 0.
- Reset asserted mid-scan: outputs go to reset values within the same cycle, without waiting for a clock edge. After Reset deasserts, the first edge with En=1, Mode=1 starts the scan at Idx=0.

## Test plan
- Reset: assert Reset with N=4, ACTIVE_LOW=1, Mode=1 scanning -> F=16'hFFFF, Idx=0, Valid=0, Wrap=0 immediately, before the next edge.
- Direct decode: En=1, Mode=0, W=5 -> one edge later F=16'hFFDF, Idx=5, Valid=1. Then W=15 -> F=16'h7FFF next cycle.
- Scan sequence: DWELL=4, Last=3, En=1, Mode=1 from DIRECT -> Idx runs 0,0,0,0,1,1,1,1,2,…,3. Wrap=1 exactly on the cycle Idx returns to 0 (cycle 16).
- Pause/resume: during the scan, drop En for 5 cycles at Idx=2, dwell=1 -> F=16'hFFFF and Valid=0 during the pause. After En=1, Idx=2 for 2 more cycles, then Idx=3.
- Last lowered mid-scan: at Idx=6, set Last=2 -> the next advance goes to Idx=0 with a Wrap pulse.
- Edge parameters: DWELL=1, Last=0 -> F=16'hFFFE constantly and Wrap=1 every cycle. With ACTIVE_LOW=0 and W=0 in direct mode -> F=16'h0001.
